// File: rtl/ppwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppwm_pkg
// Description : Shared width constants for the programmable PWM core, so the
//               ex stage and pwm_timebase always agree on counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ppwm_pkg;

    localparam int c_COUNTER_WIDTH        = 10;
    localparam int c_GLOBAL_COUNTER_WIDTH = 20;

endpackage
`default_nettype wire

// File: rtl/pwm_timebase_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase_if
// Description : Control, ex-stage link and pin signals of the PWM timebase.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_timebase_if #(
    parameter int COUNTER_WIDTH        = ppwm_pkg::c_COUNTER_WIDTH,
    parameter int GLOBAL_COUNTER_WIDTH = ppwm_pkg::c_GLOBAL_COUNTER_WIDTH
);

    logic                            en_i;
    logic                            clr_i;
    logic [COUNTER_WIDTH-1:0]        period_i;
    logic                            polarity_i;
    logic [COUNTER_WIDTH-1:0]        pwm_value_i;
    logic                            start_o;
    logic [GLOBAL_COUNTER_WIDTH-1:0] global_counter_o;
    logic                            pwm_o;

    modport master (
        output en_i, clr_i, period_i, polarity_i, pwm_value_i,
        input  start_o, global_counter_o, pwm_o
    );

    modport slave (
        input  en_i, clr_i, period_i, polarity_i, pwm_value_i,
        output start_o, global_counter_o, pwm_o
    );

endinterface
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : PWM period timebase with double-buffered period/duty and a
//               registered, glitch-free PWM output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase
    import ppwm_pkg::*;
#(
    parameter int COUNTER_WIDTH        = c_COUNTER_WIDTH,
    parameter int GLOBAL_COUNTER_WIDTH = c_GLOBAL_COUNTER_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    pwm_timebase_if.slave bus
);

    localparam int c_IDX_WIDTH = GLOBAL_COUNTER_WIDTH - COUNTER_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_IDX_WIDTH-1:0]   c_IDX_ONE = {{(c_IDX_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic [c_IDX_WIDTH-1:0]   r_idx;
    logic [COUNTER_WIDTH-1:0] r_top;
    logic [COUNTER_WIDTH-1:0] r_duty;
    logic                     r_pend;
    logic                     r_pwm;

    logic w_wrap;
    logic w_start;

    assign w_wrap  = bus.en_i & (r_cnt == r_top);
    assign w_start = r_pend & bus.en_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_top  <= '1;
            r_duty <= '0;
            r_pend <= 1'b1;
            r_pwm  <= 1'b0;
        end else begin
            // Output stage runs even while paused so the pin always tracks polarity
            r_pwm <= (r_cnt < r_duty) ^ bus.polarity_i;
            if (bus.clr_i) begin
                r_cnt  <= '0;
                r_idx  <= '0;
                r_top  <= bus.period_i;
                r_duty <= bus.pwm_value_i;
                r_pend <= 1'b1;
            end else if (bus.en_i) begin
                if (w_wrap) begin
                    r_cnt  <= '0;
                    r_idx  <= r_idx + c_IDX_ONE;
                    r_top  <= bus.period_i;
                    r_duty <= bus.pwm_value_i;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                // Consuming a start beats a wrap's re-arm: with top 0 this yields alternate pulses
                r_pend <= w_start ? 1'b0 : (w_wrap | r_pend);
            end
        end
    end

    assign bus.start_o          = w_start;
    assign bus.global_counter_o = {r_idx, r_cnt};
    assign bus.pwm_o            = r_pwm;

endmodule
`default_nettype wire

// File: tb/tb_pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_timebase
// Description : Self-checking bench for pwm_timebase with a cycle-level
//               behavioural model and directed scenario tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_timebase;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Behavioural model state (plain integers)
    int m_cnt, m_idx, m_top, m_duty, m_pend, m_pwm;

    pwm_timebase_if #(.COUNTER_WIDTH(10), .GLOBAL_COUNTER_WIDTH(20)) bus ();

    pwm_timebase #(.COUNTER_WIDTH(10), .GLOBAL_COUNTER_WIDTH(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_top = 1023; m_duty = 0; m_pend = 1; m_pwm = 0;
    endtask

    task automatic model_edge();
        int nxt_pwm;
        int started;
        nxt_pwm = ((m_cnt < m_duty) ? 1 : 0) ^ int'(bus.polarity_i);
        if (bus.clr_i) begin
            m_cnt = 0; m_idx = 0; m_pend = 1;
            m_top = int'(bus.period_i); m_duty = int'(bus.pwm_value_i);
        end else if (bus.en_i) begin
            started = m_pend;
            if (m_cnt == m_top) begin
                m_cnt  = 0;
                m_idx  = (m_idx + 1) % 1024;
                m_top  = int'(bus.period_i);
                m_duty = int'(bus.pwm_value_i);
                m_pend = (started != 0) ? 0 : 1;
            end else begin
                m_cnt = m_cnt + 1;
                if (started != 0) m_pend = 0;
            end
        end
        m_pwm = nxt_pwm;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en_i = 1'b0; bus.clr_i = 1'b0; bus.polarity_i = 1'b0;
        bus.period_i = 10'd9; bus.pwm_value_i = 10'd3;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.start_o !== 1'b0 || bus.global_counter_o !== 20'd0 || bus.pwm_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got start=%0b gc=%0d pwm=%0b exp 0/0/0",
                     bus.start_o, bus.global_counter_o, bus.pwm_o);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.en_i = 1'b1;
        #1;
        checks++;
        if (bus.start_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_start got=%0b exp=1", bus.start_o);
        end
        step(); #1;
        checks++;
        if (bus.start_o !== 1'b0 || bus.global_counter_o !== 20'd1) begin
            failures++;
            $display("FAIL reset_second_cycle got start=%0b gc=%0d exp start=0 gc=1",
                     bus.start_o, bus.global_counter_o);
        end
    endtask

    task automatic test_period();
        int starts, hi, bad;
        logic [19:0] exp_gc;
        bus.polarity_i = 1'b0; bus.period_i = 10'd9; bus.pwm_value_i = 10'd3;
        bus.en_i = 1'b1; bus.clr_i = 1'b1;
        step(); bus.clr_i = 1'b0;
        starts = 0; hi = 0; bad = 0;
        for (int i = 0; i < 30; i++) begin
            step(); #1;
            exp_gc = 20'(m_idx * 1024 + m_cnt);
            checks++;
            if (bus.start_o !== 1'(m_pend != 0) || bus.global_counter_o !== exp_gc ||
                bus.pwm_o !== 1'(m_pwm)) begin
                failures++;
                $display("FAIL period_model i=%0d got start=%0b gc=%0d pwm=%0b exp start=%0d gc=%0d pwm=%0d",
                         i, bus.start_o, bus.global_counter_o, bus.pwm_o, m_pend, exp_gc, m_pwm);
            end
            if (bus.start_o === 1'b1 && bus.global_counter_o[9:0] !== 10'd0) bad++;
            starts += int'(bus.start_o);
            hi     += int'(bus.pwm_o);
        end
        checks++;
        if (starts != 3 || bad != 0) begin
            failures++;
            $display("FAIL period_starts got=%0d misplaced=%0d exp=3", starts, bad);
        end
        checks++;
        if (hi != 9) begin
            failures++;
            $display("FAIL period_duty got=%0d exp=9", hi);
        end
        checks++;
        if (bus.global_counter_o !== 20'(3 * 1024)) begin
            failures++;
            $display("FAIL period_index got=%0d exp=%0d", bus.global_counter_o, 3 * 1024);
        end
    endtask

    task automatic test_mid_change();
        int hi;
        bus.period_i = 10'd9; bus.pwm_value_i = 10'd3; bus.en_i = 1'b1; bus.clr_i = 1'b1;
        step(); bus.clr_i = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            if (bus.global_counter_o[9:0] == 10'd5) bus.pwm_value_i = 10'd7;
            hi += int'(bus.pwm_o);
        end
        checks++;
        if (hi != 3) begin
            failures++;
            $display("FAIL mid_change_current got=%0d exp=3", hi);
        end
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            hi += int'(bus.pwm_o);
        end
        checks++;
        if (hi != 7) begin
            failures++;
            $display("FAIL mid_change_next got=%0d exp=7", hi);
        end
    endtask

    task automatic test_duty_extremes();
        int ones, exp_ones;
        for (int p = 0; p < 2; p++) begin
            for (int v = 0; v < 2; v++) begin
                bus.polarity_i = 1'(p); bus.period_i = 10'd9;
                bus.pwm_value_i = (v == 0) ? 10'd0 : 10'd10;
                bus.en_i = 1'b1; bus.clr_i = 1'b1;
                step(); bus.clr_i = 1'b0;
                ones = 0;
                for (int i = 0; i < 20; i++) begin
                    step(); #1;
                    ones += int'(bus.pwm_o);
                end
                exp_ones = ((v == 1) != (p == 1)) ? 20 : 0;
                checks++;
                if (ones != exp_ones) begin
                    failures++;
                    $display("FAIL duty_extreme pol=%0d val=%0d got_high=%0d exp_high=%0d",
                             p, (v == 0) ? 0 : 10, ones, exp_ones);
                end
            end
        end
        bus.polarity_i = 1'b0;
    endtask

    task automatic test_enable_pause();
        int starts;
        bus.period_i = 10'd9; bus.pwm_value_i = 10'd3; bus.en_i = 1'b1; bus.clr_i = 1'b1;
        step(); bus.clr_i = 1'b0; bus.en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.start_o !== 1'b0 || bus.global_counter_o !== 20'd0) begin
                failures++;
                $display("FAIL pause_frozen i=%0d got start=%0b gc=%0d exp start=0 gc=0",
                         i, bus.start_o, bus.global_counter_o);
            end
            step();
        end
        bus.en_i = 1'b1; #1;
        checks++;
        if (bus.start_o !== 1'b1) begin
            failures++;
            $display("FAIL pause_resume_start got=%0b exp=1", bus.start_o);
        end
        starts = int'(bus.start_o);
        for (int i = 0; i < 9; i++) begin
            step(); #1;
            starts += int'(bus.start_o);
        end
        checks++;
        if (starts != 1 || bus.global_counter_o !== 20'd9) begin
            failures++;
            $display("FAIL pause_single_start got starts=%0d gc=%0d exp starts=1 gc=9",
                     starts, bus.global_counter_o);
        end
    endtask

    task automatic test_wrap_around();
        int starts, odd_starts;
        bus.period_i = 10'd0; bus.pwm_value_i = 10'd0; bus.en_i = 1'b1; bus.clr_i = 1'b1;
        step(); bus.clr_i = 1'b0;
        starts = 0; odd_starts = 0;
        for (int k = 0; k <= 1026; k++) begin
            #1;
            starts += int'(bus.start_o);
            if ((k % 2) == 1 && bus.start_o === 1'b1) odd_starts++;
            if (k == 1023 || k == 1024 || k == 1026) begin
                checks++;
                if (bus.global_counter_o !== 20'((k % 1024) * 1024)) begin
                    failures++;
                    $display("FAIL wrap_index k=%0d got=%0d exp=%0d",
                             k, bus.global_counter_o, (k % 1024) * 1024);
                end
            end
            step();
        end
        checks++;
        if (starts != 514 || odd_starts != 0) begin
            failures++;
            $display("FAIL wrap_starts got=%0d odd=%0d exp=514 odd=0", starts, odd_starts);
        end
    endtask

    task automatic test_reset_clear();
        bus.period_i = 10'd9; bus.pwm_value_i = 10'd5; bus.en_i = 1'b1; bus.clr_i = 1'b1;
        step(); bus.clr_i = 1'b0;
        repeat (3) step();
        #2;
        bus.en_i = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if (bus.start_o !== 1'b0 || bus.global_counter_o !== 20'd0 || bus.pwm_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got start=%0b gc=%0d pwm=%0b exp 0/0/0",
                     bus.start_o, bus.global_counter_o, bus.pwm_o);
        end
        @(negedge clk);
        rst_n = 1'b1; model_reset();
        bus.en_i = 1'b1; bus.clr_i = 1'b1;
        step(); bus.clr_i = 1'b0;
        repeat (29) step();
        bus.clr_i = 1'b1; #1;
        checks++;
        if (bus.global_counter_o !== 20'(2 * 1024 + 9)) begin
            failures++;
            $display("FAIL clr_prewrap got=%0d exp=%0d", bus.global_counter_o, 2 * 1024 + 9);
        end
        step(); bus.clr_i = 1'b0; #1;
        checks++;
        if (bus.global_counter_o !== 20'd0 || bus.start_o !== 1'b1) begin
            failures++;
            $display("FAIL clr_on_wrap got gc=%0d start=%0b exp gc=0 start=1",
                     bus.global_counter_o, bus.start_o);
        end
    endtask

    task automatic test_random();
        logic [19:0] exp_gc;
        for (int i = 0; i < 1500; i++) begin
            bus.en_i  = ($urandom_range(0, 7) != 0);
            bus.clr_i = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) bus.period_i = 10'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) bus.pwm_value_i = 10'($urandom_range(0, 14));
            if ($urandom_range(0, 99) == 0) bus.polarity_i = ~bus.polarity_i;
            #1;
            exp_gc = 20'(m_idx * 1024 + m_cnt);
            checks++;
            if (bus.start_o !== 1'(m_pend != 0 && bus.en_i) || bus.global_counter_o !== exp_gc ||
                bus.pwm_o !== 1'(m_pwm)) begin
                failures++;
                $display("FAIL random_model i=%0d got start=%0b gc=%0d pwm=%0b exp start=%0d gc=%0d pwm=%0d",
                         i, bus.start_o, bus.global_counter_o, bus.pwm_o,
                         (m_pend != 0 && bus.en_i) ? 1 : 0, exp_gc, m_pwm);
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_period();
        test_mid_change();
        test_duty_extremes();
        test_enable_pause();
        test_wrap_around();
        test_reset_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_timebase.md
# pwm_timebase

PWM period timebase and output stage for the programmable PWM core. It generates the `start_i` pulse and the `global_counter_i` value consumed by the `ex` execution stage. It double-buffers the `pwm_value_o` that `ex` produces and drives the physical PWM pin glitch-free. Every new duty value takes effect only at a period boundary.

## Interface
- `COUNTER_WIDTH`, 10: width of the in-period counter, period length and duty value; must match `ex`.
- `GLOBAL_COUNTER_WIDTH`, 20: width of the global counter; must be greater than `COUNTER_WIDTH`.
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `en_i` input 1: count enable; low freezes all counters.
- `clr_i` input 1: synchronous restart of the timebase.
- `period_i` input COUNTER_WIDTH: period top value; period length is `period_i + 1` cycles.
- `polarity_i` input 1: 1 inverts `pwm_o`.
- `pwm_value_i` input COUNTER_WIDTH: duty value from `ex`.
- `start_o` output 1: one-cycle pulse at the start of each period; feeds `ex.start_i`.
- `global_counter_o` output GLOBAL_COUNTER_WIDTH: `{period_idx_q, cnt_q}`; feeds `ex.global_counter_i`.
- `pwm_o` output 1: registered PWM output.

## Operation
- Registers:
  - `cnt_q` (COUNTER_WIDTH): position within the period.
  - `period_idx_q` (GLOBAL_COUNTER_WIDTH − COUNTER_WIDTH): completed-period count.
  - `top_q` and `duty_q` (COUNTER_WIDTH): shadow copies of `period_i` and `pwm_value_i`.
  - `pend_q`: start pending.
  - `pwm_q`: output flop.
- Wrap condition: `wrap = en_i & (cnt_q == top_q)`.
- On `wrap`:
  - `cnt_q` goes to 0.
  - `period_idx_q` increments modulo 2^(GLOBAL_COUNTER_WIDTH − COUNTER_WIDTH), with silent wrap-around.
  - `top_q` loads `period_i` and `duty_q` loads `pwm_value_i`.
  - `pend_q` is set.
- When `en_i` is high and there is no wrap, `cnt_q` increments by 1.
- When `en_i` is low, `cnt_q`, `period_idx_q`, `top_q`, `duty_q` and `pend_q` all hold.
- `start_o = pend_q & en_i`. Asserting `start_o` clears `pend_q` on the next edge.
  - This gives exactly one pulse per period, in the first enabled cycle with `cnt_q == 0`.
  - Pausing `en_i` never duplicates or loses a start.
- `clr_i` takes priority over `wrap` and over `en_i`. It sets:
  - `cnt_q` to 0 and `period_idx_q` to 0;
  - `top_q` to `period_i` and `duty_q` to `pwm_value_i`;
  - `pend_q` to 1.
- `pwm_q` updates every cycle, independent of `en_i`: `pwm_q <= (cnt_q < duty_q) ^ polarity_i`. The comparison is unsigned.
- Duty boundary cases:
  - `duty_q == 0` gives constant inactive.
  - `duty_q > top_q` gives constant active (100 %).
- `top_q == 0`: every enabled cycle is a wrap. `start_o` pulses every second enabled cycle, because `pend_q` is cleared and then set again.
- `period_i` or `pwm_value_i` changing mid-period has no effect until the next wrap or `clr_i`.

## Timing
- Reset values (asynchronous, immediate, including mid-period):
  - `cnt_q` = 0, `period_idx_q` = 0, `top_q` = all ones, `duty_q` = 0.
  - `pend_q` = 1, `pwm_q` = 0.
  - Hence `start_o` = 0 while `en_i` is low, `global_counter_o` = 0, `pwm_o` = 0.
- Start latency:
  - After reset release with `en_i` high, `start_o` is high in the first cycle.
  - After a wrap edge, `start_o` is high in the following enabled cycle, when `cnt_q` is 0.
- `pwm_o` latency: one cycle. `pwm_o` in cycle t+1 reflects `cnt_q` and `duty_q` of cycle t, so the duty width is exact in cycles.
- A new `pwm_value_i` becomes visible on `pwm_o` in the second cycle of the following period.
- `global_counter_o` is purely registered with no combinational path from inputs. `start_o` has a combinational path from `en_i` only.
- `ex` samples `start_o` at the same edge on which `cnt_q` leaves 0.

## Structure
- Flat module; no sub-module.
- No new typedefs. `COUNTER_WIDTH` and `GLOBAL_COUNTER_WIDTH` defaults live as shared localparams in `ppwm_pkg` so that `ex` and `pwm_timebase` cannot diverge.
- Top level connections: `start_o` to `ex.start_i`, `global_counter_o` to `ex.global_counter_i`, and `ex.pwm_value_o` to `pwm_value_i`.

## Test plan
- Reset sequence:
  - Stimulus: reset, then `period_i`=9, `pwm_value_i`=3, `en_i`=1, `clr_i` for one cycle.
  - Required: `start_o` pulses every 10 cycles; `pwm_o` high for exactly 3 of every 10 cycles; `global_counter_o[19:10]` increments at each wrap.
- Mid-period change:
  - Stimulus: `pwm_value_i` changes 3 to 7 at `cnt_q`=5.
  - Required: the current period stays at 3 high cycles; the next period has 7.
- Duty extremes:
  - Stimulus: `pwm_value_i`=0, then 10 with `period_i`=9.
  - Required: `pwm_o` constant 0, then constant 1. With `polarity_i`=1, both results are inverted.
- Enable pause:
  - Stimulus: `en_i` low for 4 cycles at `cnt_q`=0 before the start is consumed.
  - Required: exactly one `start_o` pulse, in the first enabled cycle; counters frozen during the pause.
- Wrap-around:
  - Stimulus: `period_i`=0, run 2^10 + 2 wraps.
  - Required: `period_idx_q` wraps 1023 → 0; `start_o` pulses every second cycle.
- Reset and clear:
  - Stimulus: assert `rst_n` low asynchronously mid-period (between clock edges); separately, `clr_i` coincident with a wrap.
  - Required: after the reset, all outputs are 0 immediately. After the `clr_i`, `period_idx_q` = 0 rather than incremented.
